// File: rtl/toy_imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter and its users.
package toy_imem_arb_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int INST_WIDTH   = 32;
  localparam int IMEM_REQ_NUM = 2;

  // One-entry response holding register per requester
  typedef struct packed {
    logic                  vld;
    logic [INST_WIDTH-1:0] data;
  } imem_rsp_buf_t;

  // Byte address to imem word address; fetch uses the same conversion
  function automatic logic [ADDR_WIDTH-1:0] byte_to_word_addr(input logic [ADDR_WIDTH-1:0] addr);
    return {2'b00, addr[ADDR_WIDTH-1:2]};
  endfunction

endpackage

// File: rtl/toy_imem_arb_rr_arb.sv
// N-way round-robin picker: first requester at or after ptr wins; ptr_nxt
// points one past the winner, or stays at ptr when nobody is requesting.
module toy_rr_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] ptr_nxt
);

  localparam int PW = $clog2(N);

  int best;
  int best_d;
  int d;

  // Pick the requester with the smallest rotational distance from ptr
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    best    = 0;
    best_d  = N;
    d       = 0;
    for (int j = 0; j < N; j++) begin
      d = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + N - int'(ptr));
      if (req[j] && (d < best_d)) begin
        best_d = d;
        best   = j;
      end
    end
    for (int j = 0; j < N; j++) begin
      if ((best_d < N) && (j == best)) begin
        gnt[j]  = 1'b1;
        ptr_nxt = PW'((j + 1) % N);
      end
    end
  end

endmodule

// File: rtl/toy_imem_arb.sv
// Round-robin share of one 1-cycle-latency imem read port between REQ_NUM
// requesters (0 = fetch), with a one-entry response skid per requester and a
// per-requester flush for dropping stale responses.
// Optional build macro TOY_IMEM_ARB_PERF_EN adds per-requester saturating
// grant/stall counters.
module toy_imem_arb
  import toy_imem_arb_pkg::*;
#(
  parameter int REQ_NUM    = IMEM_REQ_NUM,
  parameter int ADDR_WIDTH = toy_imem_arb_pkg::ADDR_WIDTH,
  parameter int INST_WIDTH = toy_imem_arb_pkg::INST_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REQ_NUM-1:0]                  req_vld,
  output logic [REQ_NUM-1:0]                  req_rdy,
  input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [REQ_NUM-1:0]                  req_flush,
  output logic [REQ_NUM-1:0]                  rsp_vld,
  input  logic [REQ_NUM-1:0]                  rsp_rdy,
  output logic [REQ_NUM-1:0][INST_WIDTH-1:0]  rsp_pld,
  output logic                                mem_en,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  input  logic [INST_WIDTH-1:0]               mem_data
`ifdef TOY_IMEM_ARB_PERF_EN
  ,
  output logic [REQ_NUM-1:0][31:0]            perf_grant_cnt,
  output logic [REQ_NUM-1:0][31:0]            perf_stall_cnt
`endif
);

  localparam int PW = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]          inflight_q;
  imem_rsp_buf_t [REQ_NUM-1:0] buf_q;
  logic [PW-1:0]               rr_ptr_q;
  logic [PW-1:0]               rr_ptr_nxt;
  logic [REQ_NUM-1:0]          elig;
  logic [REQ_NUM-1:0]          gnt;
  logic                        addr_lsb_unused;

  // Eligibility and combinational response path; flush hides the response
  always_comb begin
    elig    = '0;
    rsp_vld = '0;
    rsp_pld = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      elig[i]    = !rst && req_vld[i] && !req_flush[i] && !buf_q[i].vld &&
                   (!inflight_q[i] || rsp_rdy[i]);
      rsp_vld[i] = !rst && !req_flush[i] && (buf_q[i].vld || inflight_q[i]);
      rsp_pld[i] = buf_q[i].vld ? buf_q[i].data : mem_data;
    end
  end

  toy_rr_arb #(.N(REQ_NUM)) u_rr_arb (
    .req     (elig),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .ptr_nxt (rr_ptr_nxt)
  );

  // Drive the memory port from the granted requester
  always_comb begin
    req_rdy  = gnt;
    mem_en   = |gnt;
    mem_addr = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (gnt[i]) mem_addr = {2'b00, req_addr[i][ADDR_WIDTH-1:2]};
    end
  end

  // Byte-offset bits never reach the word-addressed memory
  always_comb begin
    addr_lsb_unused = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) addr_lsb_unused = addr_lsb_unused ^ (^req_addr[i][1:0]);
  end

  // In-flight tracking, skid capture/drain, flush and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      buf_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      inflight_q <= gnt;
      rr_ptr_q   <= rr_ptr_nxt;
      for (int i = 0; i < REQ_NUM; i++) begin
        if (req_flush[i]) begin
          buf_q[i].vld <= 1'b0;
        end else if (inflight_q[i] && !rsp_rdy[i]) begin
          buf_q[i].vld  <= 1'b1;
          buf_q[i].data <= mem_data;
        end else if (buf_q[i].vld && rsp_rdy[i]) begin
          buf_q[i].vld <= 1'b0;
        end
      end
    end
  end

`ifdef TOY_IMEM_ARB_PERF_EN
  // Saturating per-requester grant and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (req_vld[i] && gnt[i] && (perf_grant_cnt[i] != '1))
          perf_grant_cnt[i] <= perf_grant_cnt[i] + 32'd1;
        if (req_vld[i] && !gnt[i] && !req_flush[i] && (perf_stall_cnt[i] != '1))
          perf_stall_cnt[i] <= perf_stall_cnt[i] + 32'd1;
      end
    end
  end
`endif

endmodule
